// File: rtl/vram_arbiter.sv
// -----------------------------------------------------------------------------
// vram_arbiter
//   Shares the single 8Kx16 synchronous VRAM port between the tile/sprite
//   fetcher (gfx) and the CPU byte data-port path. gfx owns the port by
//   default. A pending CPU access is granted at once when gfx is idle, or
//   after MAX_WAIT cycles of waiting while gfx is active. Each CPU access
//   stalls gfx for exactly two cycles (GRANT, DATA).
//
// Parameters
//   MAX_WAIT     cycles a pending CPU request may wait while gfx_active (1..15)
//
// Ports
//   clk, reset   clock; asynchronous active-high reset
//   gfx_active   gfx line fetch in progress
//   gfx_addr     gfx next word address (combinational from gfx)
//   gfx_wait     gfx must hold all state this cycle
//   gfx_rdata    VRAM read data to gfx (straight from vram_rddata)
//   cpu_req      CPU request, held until cpu_ack
//   cpu_wr       1 = write, 0 = read; stable while cpu_req
//   cpu_addr     CPU byte address; stable while cpu_req
//   cpu_wrdata   CPU write byte
//   cpu_ack      one-cycle completion pulse
//   cpu_rddata   read byte, valid from cpu_ack until the next ack
//   vram_addr    VRAM word address (registered inside the VRAM macro)
//   vram_wrdata  write byte replicated on both lanes
//   vram_wren    byte write enables, [1] = high byte, [0] = low byte
//   vram_rddata  VRAM data, valid one cycle after its address
//
// Build option
//   VRAM_ARB_WRBUF_EN  adds a one-entry posted write buffer: a write into an
//                      empty buffer is acked the next cycle and drains through
//                      the normal arbitration; reads wait until it is empty.
// -----------------------------------------------------------------------------
module vram_arbiter #(
  parameter int unsigned MAX_WAIT = 7
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        gfx_active,
  input  logic [12:0] gfx_addr,
  output logic        gfx_wait,
  output logic [15:0] gfx_rdata,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [13:0] cpu_addr,
  input  logic [7:0]  cpu_wrdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rddata,
  output logic [12:0] vram_addr,
  output logic [15:0] vram_wrdata,
  output logic [1:0]  vram_wren,
  input  logic [15:0] vram_rddata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    DATA  = 2'd2
  } state_t;

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  state_t      state;
  logic [3:0]  wait_cnt;
  logic [7:0]  rd_byte_q;
  logic        pending;
  logic        grant;
  logic        acc_wr;    // access being arbitrated / in flight is a write
  logic [13:0] acc_addr;  // its byte address
  logic [7:0]  acc_data;  // its write byte
  logic [7:0]  rd_sel;

`ifdef VRAM_ARB_WRBUF_EN
  logic        buf_valid;
  logic        buf_ack;
  logic        acc_buf;   // latched at grant: the access drains the buffer
  logic [13:0] buf_addr;
  logic [7:0]  buf_data;
  logic        capture;
  logic        sel_buf;

  assign capture = cpu_req && cpu_wr && !cpu_ack && !buf_valid;
  // A full buffer always goes first, so a later read sees the posted byte.
  assign pending = buf_valid || (cpu_req && !cpu_wr && !cpu_ack);
  assign sel_buf = (state == IDLE) ? buf_valid : acc_buf;
  assign acc_wr   = sel_buf;
  assign acc_addr = sel_buf ? buf_addr : cpu_addr;
  assign acc_data = sel_buf ? buf_data : cpu_wrdata;
  // Posted writes ack from the capture register; only reads ack at DATA.
  assign cpu_ack  = buf_ack || (state == DATA && !acc_buf);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      buf_valid <= 1'b0;
      buf_ack   <= 1'b0;
      acc_buf   <= 1'b0;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else begin
      buf_ack <= capture;
      if (capture) begin
        buf_valid <= 1'b1;
        buf_addr  <= cpu_addr;
        buf_data  <= cpu_wrdata;
      end else if (state == DATA && acc_buf) begin
        buf_valid <= 1'b0;
      end
      if (grant) acc_buf <= buf_valid;
    end
  end
`else
  // The ack cycle itself never counts as pending, so a request re-raised
  // the cycle after ack is treated as new.
  assign pending  = cpu_req && !cpu_ack;
  assign acc_wr   = cpu_wr;
  assign acc_addr = cpu_addr;
  assign acc_data = cpu_wrdata;
  assign cpu_ack  = (state == DATA);
`endif

  assign grant = (state == IDLE) && pending &&
                 (!gfx_active || wait_cnt == MAX_WAIT_C);

  // All port controls decode the registered state only; nothing from
  // cpu_req reaches gfx_wait combinationally.
  assign gfx_wait    = (state != IDLE);
  assign gfx_rdata   = vram_rddata;
  assign vram_addr   = (state == GRANT) ? acc_addr[13:1] : gfx_addr;
  assign vram_wrdata = {acc_data, acc_data};
  assign vram_wren   = (state == GRANT && acc_wr) ?
                       (acc_addr[0] ? 2'b10 : 2'b01) : 2'b00;

  assign rd_sel = cpu_addr[0] ? vram_rddata[15:8] : vram_rddata[7:0];
  // The RAM word for the read only exists during DATA, which is also the ack
  // cycle, so the byte is forwarded then and held in rd_byte_q afterwards.
  assign cpu_rddata = (state == DATA && !acc_wr) ? rd_sel : rd_byte_q;

  // NOTE: state is updated with non-blocking assignments so every reader in
  // this clock sees the pre-edge value regardless of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      rd_byte_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant) begin
            state    <= GRANT;
            wait_cnt <= '0;
          end else if (pending && gfx_active) begin
            if (wait_cnt != MAX_WAIT_C) wait_cnt <= wait_cnt + 4'd1;
          end else begin
            wait_cnt <= '0;
          end
        end
        GRANT: state <= DATA;
        DATA: begin
          state <= IDLE;
          if (!acc_wr) rd_byte_q <= rd_sel;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vram_arbiter
//   Self-checking bench for vram_arbiter (default build). A transaction-level
//   reference model predicts every output each cycle from the arbitration
//   rules: a request pending since cycle t0 is granted at the first cycle t
//   where gfx is idle or t - t0 reaches MAX_WAIT; the port is the CPU's at
//   t+1 and the ack comes at t+2. A shadow memory gives expected data.
// -----------------------------------------------------------------------------
module tb_vram_arbiter;

  localparam int MAX_WAIT   = 7;
  localparam int ACK_BUDGET = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        gfx_active;
  logic [12:0] gfx_addr;
  logic        gfx_wait;
  logic [15:0] gfx_rdata;
  logic        cpu_req;
  logic        cpu_wr;
  logic [13:0] cpu_addr;
  logic [7:0]  cpu_wrdata;
  logic        cpu_ack;
  logic [7:0]  cpu_rddata;
  logic [12:0] vram_addr;
  logic [15:0] vram_wrdata;
  logic [1:0]  vram_wren;
  logic [15:0] vram_rddata;

  vram_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk         (clk),
    .reset       (reset),
    .gfx_active  (gfx_active),
    .gfx_addr    (gfx_addr),
    .gfx_wait    (gfx_wait),
    .gfx_rdata   (gfx_rdata),
    .cpu_req     (cpu_req),
    .cpu_wr      (cpu_wr),
    .cpu_addr    (cpu_addr),
    .cpu_wrdata  (cpu_wrdata),
    .cpu_ack     (cpu_ack),
    .cpu_rddata  (cpu_rddata),
    .vram_addr   (vram_addr),
    .vram_wrdata (vram_wrdata),
    .vram_wren   (vram_wren),
    .vram_rddata (vram_rddata)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] init_word(input int i);
    if (i == 0)   return 16'h1234;
    if (i == 145) return 16'hBEEF;  // word 0x091
    return 16'(i * 40503) ^ 16'h5A5A;
  endfunction

  // VRAM macro: address registered, read-first, byte write enables.
  logic [15:0] mem [8192];
  initial begin
    logic [15:0] rd;
    for (int i = 0; i < 8192; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      rd = mem[vram_addr];
      if (vram_wren[1]) mem[vram_addr][15:8] = vram_wrdata[15:8];
      if (vram_wren[0]) mem[vram_addr][7:0]  = vram_wrdata[7:0];
      vram_rddata <= rd;
    end
  end

  // gfx fetcher: walks consecutive words, holding while told to wait.
  logic [12:0] gptr;
  always @(posedge clk or posedge reset) begin
    if (reset) gptr <= '0;
    else if (gfx_active && !gfx_wait) gptr <= gptr + 13'd1;
  end
  assign gfx_addr = gptr;

  // ---------------------------------------------------------------------------
  // Reference model and compare process (samples at negedge).
  // ---------------------------------------------------------------------------
  int          n_wait = 0, n_active = 0, n_fetch = 0, n_ack = 0;
  logic [12:0] obs_grant_addr;
  logic [1:0]  obs_grant_wren;
  logic [15:0] obs_grant_wrdata;

  initial begin
    logic [15:0] shadow [8192];
    int          now, req_t0, grant_t, phase;
    logic        e_wait, e_ack, gfx_cap, prev_wait;
    logic [12:0] e_addr;
    logic [1:0]  e_wren;
    logic [7:0]  exp_rd;
    logic [15:0] gfx_exp, w;
    for (int i = 0; i < 8192; i++) shadow[i] = init_word(i);
    now = 0; req_t0 = -1; grant_t = -1; exp_rd = '0;
    gfx_cap = 1'b0; gfx_exp = '0; prev_wait = 1'b0;
    forever begin
      @(negedge clk);
      n_wait   += int'(gfx_wait);
      n_active += int'(gfx_active);
      n_fetch  += int'(gfx_active && !gfx_wait);
      n_ack    += int'(cpu_ack);
      if (gfx_wait && !prev_wait) begin
        obs_grant_addr   = vram_addr;
        obs_grant_wren   = vram_wren;
        obs_grant_wrdata = vram_wrdata;
      end
      prev_wait = gfx_wait;
      if (reset) begin
        req_t0 = -1; grant_t = -1; exp_rd = '0; gfx_cap = 1'b0;
        check("rst_gfx_wait", 16'(gfx_wait), 16'd0);
        check("rst_cpu_ack", 16'(cpu_ack), 16'd0);
        check("rst_cpu_rddata", 16'(cpu_rddata), 16'd0);
        check("rst_vram_wren", 16'(vram_wren), 16'd0);
      end else begin
        phase  = (grant_t >= 0) ? now - grant_t : 0;
        e_wait = (phase == 1) || (phase == 2);
        e_ack  = (phase == 2);
        e_addr = (phase == 1) ? cpu_addr[13:1] : gfx_addr;
        e_wren = (phase == 1 && cpu_wr) ? (cpu_addr[0] ? 2'b10 : 2'b01) : 2'b00;
        if (phase == 2 && !cpu_wr) begin
          w = shadow[cpu_addr[13:1]];
          exp_rd = cpu_addr[0] ? w[15:8] : w[7:0];
        end
        check("gfx_wait", 16'(gfx_wait), 16'(e_wait));
        check("cpu_ack", 16'(cpu_ack), 16'(e_ack));
        check("vram_addr", 16'(vram_addr), 16'(e_addr));
        check("vram_wren", 16'(vram_wren), 16'(e_wren));
        check("cpu_rddata", 16'(cpu_rddata), 16'(exp_rd));
        if (e_wren != 2'b00) check("vram_wrdata", vram_wrdata, {cpu_wrdata, cpu_wrdata});
        if (gfx_cap) check("gfx_rdata", gfx_rdata, gfx_exp);
        gfx_cap = gfx_active && !e_wait;
        if (gfx_cap) gfx_exp = shadow[gfx_addr];
        if (e_wren[1]) shadow[cpu_addr[13:1]][15:8] = cpu_wrdata;
        if (e_wren[0]) shadow[cpu_addr[13:1]][7:0]  = cpu_wrdata;
        if (phase == 2) begin
          grant_t = -1;
        end else if (phase == 0) begin
          if (cpu_req) begin
            if (req_t0 < 0) req_t0 = now;
            if (!gfx_active || now - req_t0 >= MAX_WAIT) begin
              grant_t = now;
              req_t0  = -1;
            end
          end else begin
            req_t0 = -1;
          end
        end
      end
      now++;
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic rand_gfx;

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_gfx) gfx_active = ($urandom_range(0, 3) != 0);
  endtask

  // Called just after a posedge; returns just after the posedge that ends
  // the ack cycle, with cpu_req dropped. lat counts cycles from req to ack.
  task automatic cpu_access(input logic wr, input logic [13:0] addr, input logic [7:0] wdata,
                            input int drop_after, output int lat, output logic [7:0] rdata);
    cpu_req = 1'b1; cpu_wr = wr; cpu_addr = addr; cpu_wrdata = wdata;
    lat = 0; rdata = '0;
    for (int c = 1; c <= ACK_BUDGET && lat == 0; c++) begin
      @(negedge clk);
      if (cpu_ack) begin
        lat = c;
        rdata = cpu_rddata;
      end else begin
        tick();
        if (c == drop_after) gfx_active = 1'b0;
      end
    end
    if (lat == 0) begin
      total++; bad++;
      $display("FAIL ack_timeout: no ack within %0d cycles for addr %0h", ACK_BUDGET, addr);
    end
    tick();
    cpu_req = 1'b0;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int         lat, s_wait, s_act, s_fetch, s_ack, c;
    logic [7:0] rd;
    reset = 1'b1; cpu_req = 1'b0; cpu_wr = 1'b0; cpu_addr = '0; cpu_wrdata = '0;
    gfx_active = 1'b0; rand_gfx = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    tick();

    // 1: read with gfx idle
    s_wait = n_wait;
    cpu_access(1'b0, 14'h0123, 8'h00, -1, lat, rd);
    check("t1_latency", 16'(lat), 16'd3);
    check("t1_rddata", 16'(rd), 16'h00BE);
    check("t1_grant_addr", 16'(obs_grant_addr), 16'h0091);
    check("t1_gfx_wait_cycles", 16'(n_wait - s_wait), 16'd2);

    // 2: write while gfx busy -> forced slot after MAX_WAIT
    gfx_active = 1'b1; tick(); tick();
    s_act = n_active; s_fetch = n_fetch;
    cpu_access(1'b1, 14'h0400, 8'h5A, -1, lat, rd);
    check("t2_latency", 16'(lat), 16'd10);
    check("t2_wren", 16'(obs_grant_wren), 16'h0001);
    check("t2_wrdata", obs_grant_wrdata, 16'h5A5A);
    check("t2_gfx_held", 16'((n_active - s_act) - (n_fetch - s_fetch)), 16'd2);
    gfx_active = 1'b0; tick();
    cpu_access(1'b0, 14'h0400, 8'h00, -1, lat, rd);
    check("t2_readback", 16'(rd), 16'h005A);

    // 3: reset during GRANT of a read
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 14'h0123;
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!gfx_wait && c < 20);
    check("t3_reached_grant", 16'(gfx_wait), 16'd1);
    #1 reset = 1'b1;
    #1 check("t3_async_wait", 16'(gfx_wait), 16'd0);
    s_ack = n_ack;
    @(posedge clk); #1 cpu_req = 1'b0;
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) tick();
    check("t3_no_ack", 16'(n_ack - s_ack), 16'd0);

    // 4: back-to-back reads of both bytes of word 0
    cpu_access(1'b0, 14'h0000, 8'h00, -1, lat, rd);
    check("t4_lo_byte", 16'(rd), 16'h0034);
    cpu_access(1'b0, 14'h0001, 8'h00, -1, lat, rd);
    check("t4_hi_byte", 16'(rd), 16'h0012);
    check("t4_ack_spacing", 16'(lat), 16'd3);

    // 5: gfx goes idle at wait_cnt=3 -> immediate grant
    gfx_active = 1'b1; tick();
    cpu_access(1'b0, 14'h0123, 8'h00, 3, lat, rd);
    check("t5_latency", 16'(lat), 16'd6);
    gfx_active = 1'b1; tick();
    cpu_access(1'b0, 14'h0122, 8'h00, -1, lat, rd);
    check("t5_full_wait_again", 16'(lat), 16'd10);
    check("t5_rddata", 16'(rd), 16'h00EF);

    // Random traffic against the model
    rand_gfx = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic        wr;
      logic [13:0] a;
      logic [7:0]  d;
      int          gap;
      wr  = 1'($urandom_range(0, 1));
      a   = 14'($urandom_range(0, 15));
      d   = 8'($urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) tick();
      cpu_access(wr, a, d, -1, lat, rd);
    end
    rand_gfx = 1'b0;
    gfx_active = 1'b0;
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
